// File: rtl/dct_bfly_if.sv
// Bundle of the sample-in, sample-out and external-butterfly signals of dct_bfly_seq.
//   in_valid/in_ready/in_data    : input sample stream, x[0]..x[255] in natural order
//   out_valid/out_ready/out_data : output sample stream, index order 0..255
//   bf_di1/bf_di2/bf_i/bf_n      : registered operands, twiddle index and block size for the butterfly
//   bf_do1/bf_do2                : butterfly results, combinational from the operands
// slave is the sequencer side; master is the side feeding samples and hosting the butterfly.
interface dct_bfly_if #(
  parameter int unsigned DW = 25
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [DW-1:0] bf_di1;
  logic [DW-1:0] bf_di2;
  logic [6:0]    bf_i;
  logic [8:0]    bf_n;
  logic [DW-1:0] bf_do1;
  logic [DW-1:0] bf_do2;

  modport master (
    output in_valid, in_data, out_ready, bf_do1, bf_do2,
    input  in_ready, out_valid, out_data, bf_di1, bf_di2, bf_i, bf_n
  );

  modport slave (
    input  in_valid, in_data, out_ready, bf_do1, bf_do2,
    output in_ready, out_valid, out_data, bf_di1, bf_di2, bf_i, bf_n
  );
endinterface

// File: rtl/dct_bfly_seq.sv
// Sequencer for a 256-point 8-stage butterfly network with an external butterfly unit.
// Loads 256 samples into bank A, runs 8 ping-pong stages (even: A->B, odd: B->A),
// then streams bank A out in index order.
//   clk, rst : clock, synchronous active-high reset
//   bus      : dct_bfly_if slave (input stream, output stream, butterfly port)
//   busy     : high while in CALC or OUT
//   stage    : current CALC stage 0..7, 0 otherwise
module dct_bfly_seq #(
  parameter int unsigned DW = 25
) (
  input  logic         clk,
  input  logic         rst,
  dct_bfly_if.slave    bus,
  output logic         busy,
  output logic [2:0]   stage
);

  localparam int unsigned NPTS = 256;

  typedef enum logic [1:0] {S_LOAD, S_CALC, S_OUT} state_t;

  state_t        state;
  logic [7:0]    cnt;
  logic [DW-1:0] bank_a [NPTS];
  logic [DW-1:0] bank_b [NPTS];

  // Writeback addresses for the pair whose operands are currently on bf_di*
  logic          wb_en;
  logic [7:0]    wb_lo;
  logic [7:0]    wb_hi;

  logic [6:0]    mask_c;
  logic [6:0]    i_c;
  logic [7:0]    base_c;
  logic [7:0]    rd1_c;
  logic [7:0]    rd2_c;
  logic [7:0]    h_c;
  logic [8:0]    n_c;
  logic          issue_c;
  logic          load_wr_c;

  // Pair address generation: h = 128>>s is a power of two, so i = p & (h-1)
  // and the block base b*n equals 2*(p - i).
  always_comb begin
    mask_c    = 7'h7F >> stage;
    i_c       = cnt[6:0] & mask_c;
    base_c    = {cnt[6:0] & ~mask_c, 1'b0};
    rd1_c     = base_c + 8'(i_c);
    rd2_c     = base_c + (8'hFF >> stage) - 8'(i_c);
    h_c       = 8'(mask_c) + 8'd1;
    n_c       = 9'd256 >> stage;
    issue_c   = (state == S_CALC) && !cnt[7];
    load_wr_c = (state == S_LOAD) && bus.in_valid;
  end

  // Sample banks; never reset, and no write lands in a cycle where rst is high.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (load_wr_c) bank_a[cnt] <= bus.in_data;
      if (wb_en) begin
        if (stage[0]) begin
          bank_a[wb_lo] <= bus.bf_do1;
          bank_a[wb_hi] <= bus.bf_do2;
        end else begin
          bank_b[wb_lo] <= bus.bf_do1;
          bank_b[wb_hi] <= bus.bf_do2;
        end
      end
    end
  end

  // Control FSM with registered handshake and butterfly outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_LOAD;
      cnt          <= '0;
      stage        <= '0;
      busy         <= 1'b0;
      bus.in_ready <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_data <= '0;
      bus.bf_di1   <= '0;
      bus.bf_di2   <= '0;
      bus.bf_i     <= '0;
      bus.bf_n     <= 9'd256;
      wb_en        <= 1'b0;
      wb_lo        <= '0;
      wb_hi        <= '0;
    end else begin
      wb_en <= issue_c;
      if (issue_c) begin
        bus.bf_di1 <= stage[0] ? bank_b[rd1_c] : bank_a[rd1_c];
        bus.bf_di2 <= stage[0] ? bank_b[rd2_c] : bank_a[rd2_c];
        bus.bf_i   <= i_c;
        bus.bf_n   <= n_c;
        wb_lo      <= rd1_c;
        wb_hi      <= rd1_c + h_c;
      end

      case (state)
        S_LOAD: begin
          if (bus.in_valid) begin
            cnt <= cnt + 8'd1;
            if (cnt == 8'd255) begin
              state        <= S_CALC;
              cnt          <= '0;
              stage        <= '0;
              busy         <= 1'b1;
              bus.in_ready <= 1'b0;
            end
          end
        end
        S_CALC: begin
          // cnt 0..127 issue pairs; cnt 128 is the final writeback only.
          if (cnt == 8'd128) begin
            cnt <= '0;
            if (stage == 3'd7) begin
              // Final writeback only touches A[254..255], so A[0] is already settled.
              state         <= S_OUT;
              stage         <= '0;
              bus.out_valid <= 1'b1;
              bus.out_data  <= bank_a[0];
            end else begin
              stage <= stage + 3'd1;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_OUT: begin
          if (bus.out_ready) begin
            if (cnt == 8'd255) begin
              state         <= S_LOAD;
              cnt           <= '0;
              busy          <= 1'b0;
              bus.out_valid <= 1'b0;
              bus.in_ready  <= 1'b1;
            end else begin
              cnt          <= cnt + 8'd1;
              bus.out_data <= bank_a[cnt + 8'd1];
            end
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_dct_bfly_seq.sv
// Self-checking bench for dct_bfly_seq: a reference model of the 8-stage pair schedule
// predicts every butterfly operand set and the 256 outputs of each frame; outputs are
// checked from a queue as they are transferred.
module tb_dct_bfly_seq;

  localparam int unsigned DW = 25;

  logic       clk;
  logic       rst;
  logic       busy;
  logic [2:0] stage;

  dct_bfly_if #(.DW(DW)) bus ();

  dct_bfly_seq #(.DW(DW)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .busy  (busy),
    .stage (stage)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int mode = 0;          // 0: identity butterfly, 1: sum / scaled difference
  bit rdy_rand = 1'b0;
  bit chk_const = 1'b0;
  int frames_done = 0;

  logic [DW-1:0]  in_buf [256];
  logic [127:0]   bf_exp [1024];
  logic [DW-1:0]  exp_q [$];
  int             in_cnt = 0;
  bit             calc_on = 1'b0;
  int             calc_t = 0;
  bit             post_chk = 1'b0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void bfly(input int md, input logic [DW-1:0] a, input logic [DW-1:0] b,
                               input int i, output logic [DW-1:0] o1, output logic [DW-1:0] o2);
    if (md == 0) begin
      o1 = a;
      o2 = b;
    end else begin
      o1 = a + b;
      o2 = DW'((a - b) * DW'((i % 4) + 1));
    end
  endfunction

  // External butterfly stub
  logic [DW-1:0] stub_o1, stub_o2;
  always_comb bfly(mode, bus.bf_di1, bus.bf_di2, int'(bus.bf_i), stub_o1, stub_o2);
  assign bus.bf_do1 = stub_o1;
  assign bus.bf_do2 = stub_o2;

  // Reference schedule: expected operand sets and final outputs for one frame
  task automatic run_model();
    logic [DW-1:0] src [256];
    logic [DW-1:0] dst [256];
    logic [DW-1:0] d1, d2, o1, o2;
    int n, h, bb, i;
    src = in_buf;
    for (int s = 0; s < 8; s++) begin
      n = 256 >> s;
      h = n / 2;
      for (int p = 0; p < 128; p++) begin
        bb = p / h;
        i  = p % h;
        d1 = src[bb*n + i];
        d2 = src[bb*n + n - 1 - i];
        bf_exp[s*128 + p] = 128'({d1, d2, 7'(i), 9'(n)});
        bfly(mode, d1, d2, i, o1, o2);
        dst[bb*n + i]     = o1;
        dst[bb*n + h + i] = o2;
      end
      src = dst;
    end
    for (int k = 0; k < 256; k++) exp_q.push_back(src[k]);
  endtask

  // Monitor: samples at the falling edge, where inputs for the next rising edge are stable
  always @(negedge clk) begin
    int s, q;
    if (rst) begin
      in_cnt   = 0;
      exp_q.delete();
      calc_on  = 1'b0;
      calc_t   = 0;
      post_chk = 1'b0;
    end else begin
      if (calc_on) begin
        calc_t++;
        if (calc_t <= 1032) begin
          s = (calc_t - 1) / 129;
          q = (calc_t - 1) % 129;
          chk("stage", 128'(stage), 128'(s));
          chk("busy_calc", 128'(busy), 128'(1));
          chk("in_ready_calc", 128'(bus.in_ready), 128'(0));
          chk("out_valid_calc", 128'(bus.out_valid), 128'(0));
          if (q >= 1)
            chk("bf_ops", 128'({bus.bf_di1, bus.bf_di2, bus.bf_i, bus.bf_n}), bf_exp[s*128 + q - 1]);
          if (chk_const) begin
            if (calc_t == 2)
              chk("s0_p0", 128'({bus.bf_di1, bus.bf_di2, bus.bf_i, bus.bf_n}),
                  128'({25'd0, 25'd255, 7'd0, 9'd256}));
            if (calc_t == 129)
              chk("s0_p127", 128'({bus.bf_di1, bus.bf_di2, bus.bf_i, bus.bf_n}),
                  128'({25'd127, 25'd128, 7'd127, 9'd256}));
            if (calc_t == 195)
              chk("s1_p64", 128'({bus.bf_di1, bus.bf_di2, bus.bf_i, bus.bf_n}),
                  128'({25'd255, 25'd128, 7'd0, 9'd128}));
            if (calc_t == 905)
              chk("s7_p0", 128'({bus.bf_i, bus.bf_n}), 128'({7'd0, 9'd2}));
          end
        end else begin
          chk("latency_out_valid", 128'(bus.out_valid), 128'(1));
          chk("bf_hold", 128'({bus.bf_di1, bus.bf_di2, bus.bf_i, bus.bf_n}), bf_exp[1023]);
          calc_on = 1'b0;
        end
      end

      if (bus.in_valid && bus.in_ready) begin
        in_buf[in_cnt] = bus.in_data;
        in_cnt++;
        if (in_cnt == 256) begin
          run_model();
          in_cnt  = 0;
          calc_on = 1'b1;
          calc_t  = 0;
        end
      end

      if (post_chk) begin
        chk("in_ready_after", 128'(bus.in_ready), 128'(1));
        chk("out_valid_after", 128'(bus.out_valid), 128'(0));
        post_chk = 1'b0;
        frames_done++;
      end else if (bus.out_valid) begin
        chk("in_ready_out", 128'(bus.in_ready), 128'(0));
        if (exp_q.size() == 0) begin
          chk("out_unexpected", 128'(bus.out_valid), 128'(0));
        end else begin
          chk("out_data", 128'(bus.out_data), 128'(exp_q[0]));
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) post_chk = 1'b1;
          end
        end
      end
    end
  end

  // Downstream ready: steady or randomly stalling
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic send_frame(input int md, input int pat, input bit gaps);
    int  k = 0;
    int  guard = 0;
    logic hs;
    mode = md;
    while (k < 256 && guard < 4000) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
      end else begin
        bus.in_valid = 1'b1;
        case (pat)
          0:       bus.in_data = DW'(k);
          1:       bus.in_data = '0;
          default: bus.in_data = DW'($urandom);
        endcase
      end
      hs = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
      if (hs) k++;
      guard++;
    end
    chk("load_count", 128'(k), 128'(256));
  endtask

  task automatic wait_done(input int target, input int budget);
    int c = 0;
    while (frames_done < target && c < budget) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("frame_done", 128'(frames_done), 128'(target));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_in_ready"}, 128'(bus.in_ready), 128'(1));
    chk({tag, "_out_valid"}, 128'(bus.out_valid), 128'(0));
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_stage"}, 128'(stage), 128'(0));
  endtask

  initial begin
    int c;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle("rst");
    chk("rst_bf", 128'({bus.bf_di1, bus.bf_di2, bus.bf_i, bus.bf_n}),
        128'({25'd0, 25'd0, 7'd0, 9'd256}));
    rst = 1'b0;

    // Ramp input, identity butterfly, gappy input stream
    chk_const = 1'b1;
    send_frame(0, 0, 1'b1);
    bus.in_valid = 1'b0;
    wait_done(1, 3000);
    chk_const = 1'b0;

    // Zero input, real butterfly, latency check in the monitor
    send_frame(1, 1, 1'b0);
    bus.in_valid = 1'b0;
    wait_done(2, 3000);

    // Random data, in_valid held high through CALC into OUT, random output stalls
    rdy_rand = 1'b1;
    send_frame(1, 2, 1'b0);
    c = 0;
    while (!bus.out_valid && c < 2000) begin
      bus.in_data = DW'($urandom);
      @(posedge clk);
      #1;
      c++;
    end
    repeat (5) begin
      bus.in_data = DW'($urandom);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    wait_done(3, 5000);
    rdy_rand = 1'b0;

    // Reset in stage 3 at pair 40 aborts the frame
    send_frame(1, 2, 1'b0);
    bus.in_valid = 1'b0;
    c = 0;
    while (stage != 3'd3 && c < 2000) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("reach_stage3", 128'(stage), 128'(3));
    repeat (40) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_idle("abort");
    rst = 1'b0;

    // Fresh frame after the abort completes normally
    send_frame(1, 2, 1'b1);
    bus.in_valid = 1'b0;
    wait_done(4, 3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
